serial_deserializer: RTL and testbench

- Receive end of the team's serial bit link: samples a serial bit stream, one bit per enabled clock.
- Assembles WIDTH-bit words, LSB-first or MSB-first, matching the shift register's right-shift and left-shift serial output order.
- Presents each completed word on a holding register with a valid/ready handshake.
- Sits downstream of the shift-register transmitter; feeds the datapath that consumes parallel words.

---
 rtl/serial_deserializer_pkg.sv | 20 ++
 rtl/serial_deserializer_if.sv | 19 +
 rtl/serial_deserializer_bit_counter.sv | 34 +++
 rtl/serial_deserializer.sv | 157 +++++++++++++++
 tb/tb_serial_deserializer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_deserializer_pkg.sv
// Shared types and constants for the serial deserializer slice.
//   state_t    : frame FSM states (IDLE, SHIFT, PARITY)
//   DEFAULT_WIDTH : default data bits per frame
//   cnt_width  : width of a counter that must hold the value w
// The PARITY state is only reachable when SERIAL_DESERIALIZER_PARITY_EN is defined.
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Parallel-side word handshake of the serial deserializer.
//   parallelOut : completed word (producer -> consumer)
//   outValid    : parallelOut holds an unconsumed word
//   outReady    : consumer accepts the word
// master = deserializer side, slave = consumer side.
interface serial_deserializer_if
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] parallelOut;
  logic             outValid;
  logic             outReady;

  modport master (output parallelOut, output outValid, input outReady);
  modport slave  (input parallelOut, input outValid, output outReady);

endinterface

// File: rtl/serial_deserializer_bit_counter.sv
// deser_bit_counter: frame bit counter for the serial deserializer.
//   clk, rst : clock, asynchronous active-low reset (count -> 0)
//   en       : increment by one
//   load     : synchronous load to 1 (has priority over en)
//   limit    : terminal-count value
//   tc       : count == limit
module deser_bit_counter
  import deser_pkg::*;
#(
  parameter int unsigned CNT_W = cnt_width(DEFAULT_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(1);
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: receive end of the serial bit link.
// Samples serialIn once per enabled clock, assembles WIDTH-bit words
// (LSB-first or MSB-first, chosen per frame) and presents each word on a
// holding register with a valid/ready handshake.
//   clk, rst    : clock, asynchronous active-low reset
//   en          : bit-sample enable (0 freezes all shift state)
//   serialIn    : serial data bit
//   frameStart  : first bit of a frame (honoured in IDLE only)
//   msbFirst    : frame bit order, latched at frame start
//   clrOverrun  : synchronous clear of the sticky overrun flag
//   out_if      : parallelOut / outValid / outReady handshake (master)
//   busy        : frame in progress
//   overrun     : sticky, a completed word was dropped
//   parityErr   : even-parity result of the last delivered word
// Optional macro SERIAL_DESERIALIZER_PARITY_EN adds one even-parity bit per
// frame; without it parityErr is tied to 0.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic serialIn,
  input  logic frameStart,
  input  logic msbFirst,
  input  logic clrOverrun,
  serial_deserializer_if.master out_if,
  output logic busy,
  output logic overrun,
  output logic parityErr
);

  localparam int unsigned      CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] word;
  logic             msb_q;
  logic             order;
  logic             start;
  logic             shift_en;
  logic             cnt_inc;
  logic             done;
  logic             tc;
  logic             accept;

  deser_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_inc),
    .load  (start),
    .limit (LAST_DATA),
    .tc    (tc)
  );

  // tc is seen on the edge that samples the last data bit (count = WIDTH-1).
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shift_en = 1'b0;
    cnt_inc  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && frameStart) begin
          start    = 1'b1;
          shift_en = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          shift_en = 1'b1;
          cnt_inc  = 1'b1;
          if (tc) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            done    = 1'b1;
            state_d = IDLE;
`endif
          end
        end
      end
      PARITY: begin
        if (en) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The first bit uses the live msbFirst; later bits use the latched copy.
  always_comb begin
    order      = start ? msbFirst : msb_q;
    shift_next = order ? {sreg[WIDTH-2:0], serialIn}
                       : {serialIn, sreg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg    <= '0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start)    msb_q <= msbFirst;
      if (shift_en) sreg  <= shift_next;
    end
  end

  assign busy   = (state_q != IDLE);
  assign accept = !out_if.outValid || out_if.outReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_if.parallelOut <= '0;
      out_if.outValid    <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      if (done && accept) begin
        out_if.parallelOut <= word;
        out_if.outValid    <= 1'b1;
      end else if (out_if.outValid && out_if.outReady) begin
        out_if.outValid <= 1'b0;
      end
      if (done && !accept) begin
        overrun <= 1'b1;
      end else if (clrOverrun) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  // In PARITY the data is already complete in sreg; serialIn is the parity bit.
  assign word = sreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parityErr <= 1'b0;
    end else if (done && accept) begin
      parityErr <= (^sreg) ^ serialIn;
    end
  end
`else
  assign word      = shift_next;
  assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
module tb_serial_deserializer;

  localparam int W = 8;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam int FRAME_LEN = W + 1;
`else
  localparam int FRAME_LEN = W;
`endif

  logic clk;
  logic rst;
  logic en;
  logic serialIn;
  logic frameStart;
  logic msbFirst;
  logic clrOverrun;
  logic busy;
  logic overrun;
  logic parityErr;

  serial_deserializer_if #(.WIDTH(W)) ifc ();

  serial_deserializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .serialIn   (serialIn),
    .frameStart (frameStart),
    .msbFirst   (msbFirst),
    .clrOverrun (clrOverrun),
    .out_if     (ifc),
    .busy       (busy),
    .overrun    (overrun),
    .parityErr  (parityErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Collects the bits of a frame in a queue and builds the word arithmetically.
  bit               mbits[$];
  logic [W:0]       sb[$];        // {parityErr, word} expected at the consumer
  logic             m_busy, m_msb, m_valid, m_ovr;
  logic             m_done, m_set_ovr, m_pe;
  logic [W-1:0]     m_w;

  function automatic logic [W-1:0] assemble(input bit q[$], input bit msb);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) r[W-1-i] = q[i];
      else     r[i]     = q[i];
    end
    return r;
  endfunction

  function automatic logic qxor(input bit q[$]);
    logic x;
    x = 1'b0;
    foreach (q[i]) x = x ^ q[i];
    return x;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_msb = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
      mbits.delete();
      sb.delete();
    end else begin
      m_done = 1'b0;
      m_set_ovr = 1'b0;
      if (en) begin
        if (!m_busy) begin
          if (frameStart) begin
            mbits.delete();
            mbits.push_back(serialIn);
            m_msb  = msbFirst;
            m_busy = 1'b1;
          end
        end else begin
          mbits.push_back(serialIn);
          if (mbits.size() == FRAME_LEN) begin
            m_done = 1'b1;
            m_busy = 1'b0;
          end
        end
      end
      if (m_done) begin
        m_w = assemble(mbits, m_msb);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        m_pe = qxor(mbits);
`else
        m_pe = 1'b0;
`endif
        if (!m_valid || ifc.outReady) begin
          m_valid = 1'b1;
          sb.push_back({m_pe, m_w});
        end else begin
          m_set_ovr = 1'b1;
        end
      end else if (m_valid && ifc.outReady) begin
        m_valid = 1'b0;
      end
      if (m_set_ovr) m_ovr = 1'b1;
      else if (clrOverrun) m_ovr = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("busy", busy, m_busy);
      check("outValid", ifc.outValid, m_valid);
      check("overrun", overrun, m_ovr);
      if (ifc.outValid) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 0, 1);
        end else begin
          check("word", ifc.parallelOut, sb[0][W-1:0]);
          check("parityErr", parityErr, sb[0][W]);
          if (ifc.outReady) void'(sb.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic pick(input int m);
    if (m == 2) return 1'($urandom_range(0, 1));
    return (m != 0);
  endfunction

  // seq[i] is the i-th bit on the wire; rdy/last_rdy: 0, 1 or 2 (random)
  task automatic send_frame(input logic [W-1:0] seq, input bit msb, input bit par,
                            input bit gaps, input int rdy, input int last_rdy);
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (gaps && i > 0) begin
        en = 1'b0;
        serialIn   = 1'($urandom_range(0, 1));
        frameStart = 1'($urandom_range(0, 1));
        msbFirst   = 1'($urandom_range(0, 1));
        ifc.outReady = pick(rdy);
        clrOverrun = 1'b0;
        step();
      end
      en = 1'b1;
      serialIn   = (i < W) ? seq[i] : par;
      frameStart = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      msbFirst   = (i == 0) ? msb  : 1'($urandom_range(0, 1));
      ifc.outReady = (i == FRAME_LEN - 1) ? pick(last_rdy) : pick(rdy);
      clrOverrun = (rdy == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
      step();
    end
    en = 1'b0; frameStart = 1'b0; ifc.outReady = 1'b0; clrOverrun = 1'b0;
  endtask

  task automatic consume();
    ifc.outReady = 1'b1;
    step();
    ifc.outReady = 1'b0;
    check("consumed_valid", ifc.outValid, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word"}, ifc.parallelOut, '0);
    check({tag, "_valid"}, ifc.outValid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ovr"}, overrun, 1'b0);
    check({tag, "_perr"}, parityErr, 1'b0);
  endtask

  localparam logic [W-1:0] SEQ_A = 8'b0100_1101;  // wire order 1,0,1,1,0,0,1,0

  initial begin
    rst = 1'b0; en = 1'b0; serialIn = 1'b0; frameStart = 1'b0;
    msbFirst = 1'b0; clrOverrun = 1'b0; ifc.outReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk); #2;
    rst = 1'b1;
    step();

    // LSB-first
    send_frame(SEQ_A, 1'b0, ^SEQ_A, 1'b0, 0, 0);
    check("lsb_word", ifc.parallelOut, 8'h4D);
    check("lsb_valid", ifc.outValid, 1'b1);
    check("lsb_busy", busy, 1'b0);
    consume();

    // MSB-first
    send_frame(SEQ_A, 1'b1, ^SEQ_A, 1'b0, 0, 0);
    check("msb_word", ifc.parallelOut, 8'hB2);
    consume();

    // en gaps
    send_frame(SEQ_A, 1'b0, ^SEQ_A, 1'b1, 0, 0);
    check("gap_word", ifc.parallelOut, 8'h4D);
    consume();

    // back-to-back with consumer stalled -> overrun
    send_frame(SEQ_A, 1'b0, ^SEQ_A, 1'b0, 0, 0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0, 0);
    check("ovr_word_kept", ifc.parallelOut, 8'h4D);
    check("ovr_set", overrun, 1'b1);
    clrOverrun = 1'b1;
    step();
    clrOverrun = 1'b0;
    check("ovr_clear", overrun, 1'b0);
    consume();

    // completion coincident with consumption
    send_frame(SEQ_A, 1'b0, ^SEQ_A, 1'b0, 0, 0);
    send_frame(8'h35, 1'b1, 1'b0, 1'b0, 0, 1);
    check("coinc_valid", ifc.outValid, 1'b1);
    check("coinc_word", ifc.parallelOut, 8'hAC);
    check("coinc_ovr", overrun, 1'b0);
    consume();

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    send_frame(SEQ_A, 1'b0, 1'b1, 1'b0, 0, 0);
    check("par_err1", parityErr, 1'b1);
    consume();
    send_frame(SEQ_A, 1'b0, 1'b0, 1'b0, 0, 0);
    check("par_err0", parityErr, 1'b0);
    consume();
`endif

    // randomized traffic
    repeat (40) begin
      send_frame(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 2, 2);
      repeat ($urandom_range(0, 2)) begin
        ifc.outReady = 1'($urandom_range(0, 1));
        step();
      end
      ifc.outReady = 1'b0;
    end
    ifc.outReady = 1'b1;
    step();
    clrOverrun = 1'b1;
    step();
    ifc.outReady = 1'b0; clrOverrun = 1'b0;

    // reset in the middle of a frame with a held word and overrun set
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 0, 0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; serialIn = SEQ_A[i]; frameStart = (i == 0); msbFirst = 1'b0;
      step();
    end
    en = 1'b0; frameStart = 1'b0;
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_valid", ifc.outValid, 1'b1);
    check("pre_rst_ovr", overrun, 1'b1);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #2;
    rst = 1'b1;
    step();
    send_frame(SEQ_A, 1'b0, ^SEQ_A, 1'b0, 0, 0);
    check("post_rst_word", ifc.parallelOut, 8'h4D);
    consume();

    // drain
    ifc.outReady = 1'b1;
    repeat (3) step();
    ifc.outReady = 1'b0;
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
